// File: rtl/i2c_target_regfile.sv
// I2C target with a parametrised 8-bit register file, auto-increment pointer and read-only slots.
// Define I2C_GENCALL_EN to ACK the general-call address and honour its 0x06 reset command.
module i2c_target_regfile #(
  parameter int unsigned         REGCOUNT    = 32,
  parameter logic [6:0]          ADDR_BASE   = 7'h20,
  parameter int unsigned         ASEL_W      = 2,
  parameter logic [REGCOUNT-1:0] RO_MASK     = {REGCOUNT{1'b0}},
  parameter int unsigned         SYNC_STAGES = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              SCL_in,
  input  logic                              SDA_in,
  input  logic [(ASEL_W > 0 ? ASEL_W : 1)-1:0] addr_sel,
  input  logic [8*REGCOUNT-1:0]             ro_in,
  output logic                              SDA_out,
  output logic [8*REGCOUNT-1:0]             registers_packed,
  output logic [REGCOUNT-1:0]               wr_strobe,
  output logic                              busy
);

  localparam int unsigned PTR_W = (REGCOUNT > 1) ? $clog2(REGCOUNT) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // Bus synchronisers plus one history flop per line; idle bus reads high.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t            state_q, state_n;
  logic [3:0]        bit_cnt_q, cnt_n;
  logic [7:0]        rx_q, rx_n, tx_q, tx_n;
  logic              sda_q, sda_n, busy_q, busy_n, gc_q, gc_n, nack_q, nack_n;
  logic [PTR_W-1:0]  ptr_q, ptr_n, ptr_inc;
  logic              wr_en, gc_clear;
  logic [7:0]        regs [REGCOUNT];
  logic [7:0]        rd_byte;
  logic [6:0]        my_addr;
  logic              addr_match, ptr_ok, rx_phase, byte_fall;

  always_comb begin
    my_addr = ADDR_BASE;
    for (int i = 0; i < int'(ASEL_W); i++) my_addr[i] = addr_sel[i];
  end

  always_comb begin
    rd_byte = regs[ptr_q];
    if (RO_MASK[ptr_q]) rd_byte = ro_in[{ptr_q, 3'b000} +: 8];
  end

  assign addr_match = (rx_q[7:1] == my_addr);
  assign ptr_ok     = ({1'b0, rx_q} < 9'(REGCOUNT));
  assign ptr_inc    = (ptr_q == PTR_W'(REGCOUNT - 1)) ? '0 : ptr_q + 1'b1;
  assign rx_phase   = (state_q == ADDR) || (state_q == PTR) || (state_q == WDATA);
  assign byte_fall  = scl_fall && (bit_cnt_q == 4'd8);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first, so no path can infer a latch.
    state_n  = state_q;
    cnt_n    = bit_cnt_q;
    rx_n     = rx_q;
    tx_n     = tx_q;
    sda_n    = sda_q;
    busy_n   = busy_q;
    ptr_n    = ptr_q;
    gc_n     = gc_q;
    nack_n   = nack_q;
    wr_en    = 1'b0;
    gc_clear = 1'b0;

    if (stop_det) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
      gc_n    = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      sda_n   = 1'b1;
      gc_n    = 1'b0;
    end else begin
      if (scl_rise && rx_phase && bit_cnt_q < 4'd8) begin
        rx_n  = {rx_q[6:0], sda_s};
        cnt_n = bit_cnt_q + 4'd1;
      end
      if (scl_rise && state_q == RDATA_ACK) nack_n = sda_s;

      case (state_q)
        ADDR: if (byte_fall) begin
          if (addr_match) begin
            state_n = ADDR_ACK;
            sda_n   = 1'b0;
            busy_n  = 1'b1;
          end
`ifdef I2C_GENCALL_EN
          else if (rx_q == 8'h00) begin
            state_n = ADDR_ACK;
            sda_n   = 1'b0;
            busy_n  = 1'b1;
            gc_n    = 1'b1;
          end
`endif
          else begin
            state_n = IGNORE;
            busy_n  = 1'b0;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rx_q[0]) begin
            // Read byte is latched here so later register writes cannot tear it.
            state_n = RDATA;
            sda_n   = rd_byte[7];
            tx_n    = {rd_byte[6:0], 1'b0};
            cnt_n   = 4'd1;
            ptr_n   = ptr_inc;
          end else begin
            state_n = PTR;
            sda_n   = 1'b1;
            cnt_n   = '0;
          end
        end
        PTR: if (byte_fall) begin
          if (gc_q) begin
            state_n  = PTR_ACK;
            sda_n    = 1'b0;
            gc_clear = (rx_q == 8'h06);
            if (rx_q == 8'h06) ptr_n = '0;
          end else if (ptr_ok) begin
            state_n = PTR_ACK;
            sda_n   = 1'b0;
            ptr_n   = rx_q[PTR_W-1:0];
          end else begin
            state_n = IGNORE;
          end
        end
        PTR_ACK: if (scl_fall) begin
          state_n = gc_q ? PTR : WDATA;
          sda_n   = 1'b1;
          cnt_n   = '0;
        end
        WDATA: if (byte_fall) begin
          state_n = WDATA_ACK;
          sda_n   = 1'b0;
          wr_en   = ~RO_MASK[ptr_q];
          ptr_n   = ptr_inc;
        end
        WDATA_ACK: if (scl_fall) begin
          state_n = WDATA;
          sda_n   = 1'b1;
          cnt_n   = '0;
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            state_n = RDATA_ACK;
            sda_n   = 1'b1;
          end else begin
            sda_n = tx_q[7];
            tx_n  = {tx_q[6:0], 1'b0};
            cnt_n = bit_cnt_q + 4'd1;
          end
        end
        RDATA_ACK: if (scl_fall) begin
          if (!nack_q) begin
            state_n = RDATA;
            sda_n   = rd_byte[7];
            tx_n    = {rd_byte[6:0], 1'b0};
            cnt_n   = 4'd1;
            ptr_n   = ptr_inc;
          end else begin
            state_n = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      gc_q      <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      bit_cnt_q <= cnt_n;
      rx_q      <= rx_n;
      tx_q      <= tx_n;
      sda_q     <= sda_n;
      busy_q    <= busy_n;
      ptr_q     <= ptr_n;
      gc_q      <= gc_n;
      nack_q    <= nack_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the register file is reset explicitly because software relies on zeroed contents.
      for (int i = 0; i < REGCOUNT; i++) regs[i] <= '0;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (gc_clear) begin
        for (int i = 0; i < REGCOUNT; i++) regs[i] <= '0;
      end else if (wr_en) begin
        regs[ptr_q]      <= rx_q;
        wr_strobe[ptr_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    registers_packed = '0;
    for (int i = 0; i < REGCOUNT; i++)
      registers_packed[8*i +: 8] = RO_MASK[i] ? 8'h00 : regs[i];
  end

  assign SDA_out = sda_q;
  assign busy    = busy_q;

endmodule
